// File: rtl/pattern_pkg.sv
// Shared types and helpers for the pattern player (show phase of the memory game).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_pkg;

  localparam int LEVEL_W    = 4;
  localparam int SYM_W_DFLT = 2;

  typedef logic [SYM_W_DFLT-1:0] sym_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHOW,
    ST_GAP,
    ST_DONE
  } state_e;

  // Tick border for a difficulty level: base minus level*step, floored.
  // Done in signed 32-bit so high levels that go negative still clamp.
  function automatic int calc_border(input int base, input int step,
                                     input int floor_val,
                                     input logic [LEVEL_W-1:0] lvl);
    int raw;
    raw = base - int'(lvl) * step;
    return (raw < floor_val) ? floor_val : raw;
  endfunction

endpackage

// File: rtl/pattern_player_tick_gen.sv
// Clearable slow-tick divider: one-cycle tick every border+1 clocks.
// Latency: first tick border+1 cycles after clr; tick is combinational from count.
// Backpressure: none; free-running whenever not cleared.
module tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  int   border,
  output logic tick
);

  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        wrap;

  // Wrap on >= rather than == so a border lowered mid-count cannot strand
  // the counter above it and stall ticks for ~2^32 cycles.
  assign wrap = (count_q >= 32'($unsigned(border)));

  // Next count and tick strobe.
  always_comb begin
    count_d = count_q + 32'd1;
    tick    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
      tick    = 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pattern_player.sv
// Plays a stored symbol pattern on the LEDs: each symbol lit ON_TICKS ticks, then OFF_TICKS blank.
// Latency: start -> FETCH next cycle, first symbol lit the cycle after; done pulses after the last gap.
// Backpressure: none; start is ignored while busy, abort ends playback at once without done.
module pattern_player
  import pattern_pkg::*;
#(
  parameter int SYM_W       = 2,
  parameter int LEN_W       = 4,
  parameter int BASE_BORDER = 25_000_000,
  parameter int STEP        = 2_500_000,
  parameter int MIN_BORDER  = 5_000_000,
  parameter int ON_TICKS    = 2,
  parameter int OFF_TICKS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [LEVEL_W-1:0] level,
  input  logic [LEN_W:0]     length,
  output logic [LEN_W-1:0]   mem_addr,
  input  logic [SYM_W-1:0]   mem_data,
  output logic [SYM_W-1:0]   led_sym,
  output logic               led_on,
  output logic               busy,
  output logic               done
);

  localparam int TC_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TC_W   = (TC_MAX < 2) ? 1 : $clog2(TC_MAX + 1);

  localparam logic [TC_W-1:0] ON_LAST  = TC_W'(ON_TICKS - 1);
  localparam logic [TC_W-1:0] OFF_LAST = TC_W'(OFF_TICKS - 1);

  state_e            state_q;
  logic [LEN_W-1:0]  idx_q;
  logic [LEN_W:0]    len_q;
  int                border_q;
  logic [TC_W-1:0]   tick_cnt_q;
  logic [LEN_W-1:0]  mem_addr_q;
  logic [SYM_W-1:0]  led_sym_q;
  logic              led_on_q;
  logic              busy_q;
  logic              done_q;

  logic              tick;
  logic              accept_start;
  logic              playing;
  logic              last_sym;

  // A start only counts in IDLE and loses to a simultaneous abort.
  assign accept_start = (state_q == ST_IDLE) && start && !abort;
  assign playing      = (state_q == ST_FETCH) || (state_q == ST_SHOW) ||
                        (state_q == ST_GAP);
  assign last_sym     = ({1'b0, idx_q} == (len_q - 1'b1));

  // Tick timebase restarts on every accepted start so the first symbol gets full ticks.
  tick_gen u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (accept_start),
    .border (border_q),
    .tick   (tick)
  );

  // Playback sequencer; all LED/handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      len_q      <= '0;
      border_q   <= BASE_BORDER;
      tick_cnt_q <= '0;
      mem_addr_q <= '0;
      led_sym_q  <= '0;
      led_on_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && playing) begin
        // Abort beats any tick in the same cycle; no done is raised.
        state_q  <= ST_IDLE;
        led_on_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept_start) begin
              border_q <= calc_border(BASE_BORDER, STEP, MIN_BORDER, level);
              if (length != '0) begin
                state_q    <= ST_FETCH;
                len_q      <= length;
                idx_q      <= '0;
                mem_addr_q <= '0;
                busy_q     <= 1'b1;
              end else begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            end
          end

          ST_FETCH: begin
            // mem_addr was set to 0 at start; read data is valid this cycle.
            led_sym_q  <= mem_data;
            led_on_q   <= 1'b1;
            tick_cnt_q <= '0;
            state_q    <= ST_SHOW;
          end

          ST_SHOW: begin
            if (tick) begin
              if (tick_cnt_q == ON_LAST) begin
                state_q    <= ST_GAP;
                led_on_q   <= 1'b0;
                tick_cnt_q <= '0;
                // Prefetch the next symbol during the gap; wrap on the last one is unused.
                mem_addr_q <= idx_q + 1'b1;
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
          end

          ST_GAP: begin
            if (tick) begin
              if (tick_cnt_q == OFF_LAST) begin
                tick_cnt_q <= '0;
                if (last_sym) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  idx_q     <= idx_q + 1'b1;
                  led_sym_q <= mem_data;
                  led_on_q  <= 1'b1;
                  state_q   <= ST_SHOW;
                end
              end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
              end
            end
          end

          ST_DONE: begin
            state_q <= ST_IDLE;
          end

          default: begin
            state_q  <= ST_IDLE;
            led_on_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_addr = mem_addr_q;
  assign led_sym  = led_sym_q;
  assign led_on   = led_on_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pattern_player.sv
// Scoreboard bench for pattern_player with a small, fast tick configuration.
// Latency: expected per-cycle outputs are derived from the symbol/gap timeline.
// Backpressure: n/a.
module tb_pattern_player;
  import pattern_pkg::*;

  localparam int SYM_W = 2;
  localparam int LEN_W = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic               abort;
  logic [3:0]         level;
  logic [LEN_W:0]     length;
  logic [LEN_W-1:0]   mem_addr;
  logic [SYM_W-1:0]   mem_data;
  logic [SYM_W-1:0]   led_sym;
  logic               led_on;
  logic               busy;
  logic               done;

  sym_t pat [16];
  int   checks   = 0;
  int   failures = 0;
  int   exp_q [$];

  always #5 clk = ~clk;

  assign mem_data = pat[mem_addr];

  pattern_player #(
    .SYM_W       (SYM_W),
    .LEN_W       (LEN_W),
    .BASE_BORDER (9),
    .STEP        (2),
    .MIN_BORDER  (3),
    .ON_TICKS    (2),
    .OFF_TICKS   (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .level    (level),
    .length   (length),
    .mem_addr (mem_addr),
    .mem_data (mem_data),
    .led_sym  (led_sym),
    .led_on   (led_on),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int border_of(input int lvl);
    int raw;
    raw = 9 - 2 * lvl;
    return (raw < 3) ? 3 : raw;
  endfunction

  // Encoded {busy, done, led_on, sym-if-lit}.
  function automatic int obs();
    return int'({busy, done, led_on, (led_on ? led_sym : 2'b00)});
  endfunction

  // Timeline with ON=2, OFF=1, tick period p, start in cycle 0:
  // FETCH in cycle 1; symbol k occupies a 3p-cycle slot starting at 3pk+1,
  // lit for the first 2p cycles (minus the FETCH cycle for k=0), blank for p.
  function automatic int exp_at(input int c, input int p, input int l);
    int b, d, on, sym, k, r;
    b = 0; d = 0; on = 0; sym = 0;
    if (c >= 1 && c <= 3 * p * l) begin
      b = 1;
      k = (c - 1) / (3 * p);
      r = c - 3 * p * k;
      if (r <= 2 * p && !(k == 0 && r == 1)) begin
        on  = 1;
        sym = int'(pat[k]);
      end
    end
    if (c == 3 * p * l + 1) d = 1;
    return (b << 4) | (d << 3) | (on << 2) | sym;
  endfunction

  task automatic play(input int lvl, input int len, input int abort_at,
                      input int mid_at, input int rst_at, input string tag);
    int p, stop, last, e;
    p    = border_of(lvl) + 1;
    stop = (abort_at >= 0) ? abort_at : rst_at;
    if (abort_at >= 0)    last = abort_at + 1;
    else if (rst_at >= 0) last = rst_at + 3;
    else                  last = 3 * p * len + 2;
    for (int c = 1; c <= last; c++) begin
      exp_q.push_back((stop >= 0 && c > stop) ? 0 : exp_at(c, p, len));
    end
    level  = 4'(lvl);
    length = 5'(len);
    start  = 1'b1;
    abort  = 1'b0;
    for (int c = 1; c <= last; c++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      e = exp_q.pop_front();
      chk_eq($sformatf("%s_c%0d", tag, c), obs(), e);
      if ((rst_at >= 0 && c > rst_at) || len == 0)
        chk_eq($sformatf("%s_addr_c%0d", tag, c), int'(mem_addr), 0);
      if (c == abort_at) abort = 1'b1;
      if (c == mid_at) begin
        start = 1'b1;
        level = 4'd0;
      end
      if (c == rst_at) rst_n = 1'b0;
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    level  = '0;
    length = '0;
    for (int i = 0; i < 16; i++) pat[i] = sym_t'(i % 4);
    pat[0] = 2'd2;
    pat[1] = 2'd1;
    pat[2] = 2'd3;

    repeat (3) step();
    chk_eq("reset_outs", obs(), 0);
    chk_eq("reset_addr", int'(mem_addr), 0);
    rst_n = 1'b1;
    step();

    // Border clamp via symbol/gap timing: periods 10, 6, 4.
    play(0, 1, -1, -1, -1, "lvl0");
    play(2, 3, -1, -1, -1, "lvl2");
    play(5, 1, -1, -1, -1, "lvl5");

    // Normal two-symbol playback at level 3.
    play(3, 2, -1, -1, -1, "normal");

    // Start mid-SHOW with a different level must not disturb timing.
    play(3, 2, -1, 5, -1, "midstart");

    // Abort in GAP at cycle 10, then replay from symbol 0 starting at cycle 12.
    play(3, 2, 10, -1, -1, "abort");
    play(3, 2, -1, -1, -1, "replay");

    // start and abort together in IDLE: stays idle, address untouched.
    level  = 4'd3;
    length = 5'd2;
    start  = 1'b1;
    abort  = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk_eq("sa_idle0", obs(), 0);
    step();
    chk_eq("sa_idle1", obs(), 0);
    chk_eq("sa_addr", int'(mem_addr), 2);

    // Reset at cycle 5 of a playback.
    play(3, 2, -1, -1, 5, "midrst");

    // Zero length: done next cycle, nothing lit, address stays 0.
    play(3, 0, -1, -1, -1, "zerolen");

    chk_eq("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Sequencer for the memory game's "show" phase: plays a stored symbol pattern on the LEDs, one symbol at a time.
- Each symbol is lit for a fixed number of slow ticks, followed by a blank gap.
- Tick rate is set per difficulty level: higher level gives a shorter tick period.
- Sits between the game FSM (start/abort/level/length, done) and the pattern store plus LED drivers; owns its own clearable tick generator.

Parameters:
- SYM_W, 2, width of one pattern symbol (LED index).
- LEN_W, 4, pattern address width; max pattern length is 2**LEN_W.
- BASE_BORDER, 25_000_000, tick border at level 0 (tick period = border+1 clk cycles).
- STEP, 2_500_000, border reduction per level.
- MIN_BORDER, 5_000_000, floor for the computed border; must be >= 1.
- ON_TICKS, 2, ticks each symbol stays lit (>= 1).
- OFF_TICKS, 1, ticks of blank gap after each symbol (>= 1).

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, synchronous active-low reset (one clock domain, reset sampled on posedge clk).
- start, input, 1, level pulse from the game FSM; begin playback.
- abort, input, 1, stop playback immediately, no done.
- level, input, 4, difficulty level, sampled at start.
- length, input, LEN_W+1, number of symbols to play (0..2**LEN_W), sampled at start.
- mem_addr, output, LEN_W, registered address into the pattern store.
- mem_data, input, SYM_W, combinational read data for mem_addr (same-cycle valid).
- led_sym, output, SYM_W, symbol currently displayed.
- led_on, output, 1, LED enable.
- busy, output, 1, high from FETCH through the final GAP.
- done, output, 1, one-cycle pulse at normal completion.

Behaviour:
- Reset (rst_n=0 at a posedge): state IDLE; mem_addr=0, led_sym=0, led_on=0, busy=0, done=0; tick generator cleared; latched border=BASE_BORDER. Reset mid-playback has the same effect and raises no done.
- Border latch at start: border = BASE_BORDER - level*STEP, computed 32-bit signed; if the result is < MIN_BORDER (including negative), border = MIN_BORDER. Border is held constant until the next start.
- Tick generator: 32-bit count. On clr, count=0. Otherwise, count==border gives tick=1 and count<=0; else count<=count+1. The first tick comes exactly border+1 cycles after clr.
- FSM states: IDLE, FETCH, SHOW, GAP, DONE.
- IDLE:
  - start=1 and length!=0: go to FETCH. Latch length and border, mem_addr<=0, clr tick generator.
  - start=1 and length==0: go to DONE directly.
  - start while not IDLE is ignored.
- FETCH (1 cycle): busy=1; led_sym<=mem_data; go to SHOW with led_on<=1 and tick_cnt<=0.
- SHOW: on each tick, tick_cnt++. On the ON_TICKS-th tick: go to GAP, led_on<=0, tick_cnt<=0, mem_addr<=idx+1 (wraps within LEN_W, harmless on last symbol).
- GAP: on the OFF_TICKS-th tick:
  - idx==length-1: go to DONE.
  - else: idx++, led_sym<=mem_data, led_on<=1, go to SHOW.
- DONE (1 cycle): done=1, busy=0, led_on=0; then IDLE.
- abort=1 in FETCH, SHOW or GAP: next state IDLE, led_on=0, busy=0, no done.
  - abort has priority over tick in the same cycle.
  - In IDLE, abort wins over start in the same cycle: stay IDLE.
- Ticks arriving in IDLE or DONE are ignored.
- Tick and state change in the same cycle: the tick is counted by the state active in that cycle.

Decomposition:
- Package pattern_pkg holds:
  - the state enum typedef;
  - typedef sym_t (logic [SYM_W-1:0]);
  - constant LEVEL_W=4.
- One sub-module, tick_gen: clk, rst_n, clr, border (int), tick. It is a resettable, clearable variant of the team's divider, so border changes never leave count above border.

Test Plan:
All scenarios use a bench override of BASE_BORDER=9, STEP=2, MIN_BORDER=3, ON_TICKS=2, OFF_TICKS=1.
- Border clamp: level=0 gives border 9; level=2 gives 5; level=5 gives 3 (raw result -1 clamped). Check by measuring the tick period: 10, 6 and 4 cycles.
- Normal play: level=3 (border 3), length=2, pattern {2,1}, start at cycle 0.
  - FETCH at cycle 1.
  - led_on=1 with sym 2 in cycles 2..8; blank 9..12.
  - sym 1 in cycles 13..20; blank 21..24.
  - done=1 at cycle 25 only; busy=1 in cycles 1..24.
- Zero length: length=0 with start gives done=1 the next cycle; led_on is never set; mem_addr stays 0.
- Abort: level=3, abort asserted at cycle 10 (GAP) gives IDLE at cycle 11, led_on=0, busy=0, no done. A new start at cycle 12 replays from symbol 0.
- Ignored/priority cases:
  - start pulsed mid-SHOW: no change in timing or latched level.
  - start and abort together in IDLE: remains IDLE.
- Reset mid-operation: rst_n=0 at cycle 5 gives all outputs at reset values at cycle 6 and no done.
